// File: rtl/attn_pass_scheduler.sv
// Sequencer for the shared matmul/MAC engine. It reads the input and weight
// headers, derives dimensions and SRAM base addresses, then issues the Q, K, V,
// S=Q*K^T and Z=S*V passes in order over a start/done handshake.
module attn_pass_scheduler #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DIM_W       = 16,
  parameter int unsigned TIMEOUT_CYC = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              dut_valid,
  output logic              dut_ready,
  output logic              hdr_rd_active,
  output logic [ADDR_W-1:0] hdr_read_address,
  input  logic [31:0]       tb__dut__sram_input_read_data,
  input  logic [31:0]       tb__dut__sram_weight_read_data,
  output logic              eng_start,
  input  logic              eng_done,
  output logic [2:0]        pass_id,
  output logic              cfg_a_sel,
  output logic              cfg_b_sel,
  output logic              cfg_b_transpose,
  output logic [ADDR_W-1:0] cfg_a_base,
  output logic [ADDR_W-1:0] cfg_b_base,
  output logic [ADDR_W-1:0] cfg_c_base,
  output logic [ADDR_W-1:0] cfg_s_base,
  output logic              cfg_copy_scratch,
  output logic [DIM_W-1:0]  cfg_m,
  output logic [DIM_W-1:0]  cfg_k,
  output logic [DIM_W-1:0]  cfg_n,
  output logic              err
);

  localparam int unsigned ProdW = 2 * DIM_W;
  // 4*N*Wc + N*N needs three guard bits above a single product.
  localparam int unsigned EndW = ProdW + 3;
  localparam logic [EndW-1:0] EndLimit = EndW'(1) << ADDR_W;

  typedef enum logic [2:0] {
    StIdle, StHdrRd, StHdrLat, StCalc, StIssue, StWait, StDone
  } state_e;

  typedef struct packed {
    logic              a_sel;
    logic              b_sel;
    logic              b_tr;
    logic              copy;
    logic [ADDR_W-1:0] a_base;
    logic [ADDR_W-1:0] b_base;
    logic [ADDR_W-1:0] c_base;
    logic [ADDR_W-1:0] s_base;
    logic [DIM_W-1:0]  m;
    logic [DIM_W-1:0]  k;
    logic [DIM_W-1:0]  n;
  } cfg_t;

  state_e            state_q, state_d;
  logic [DIM_W-1:0]  n_q, n_d, d_q, d_d, wr_q, wr_d, wc_q, wc_d;
  logic [ADDR_W-1:0] p_q, p_d, wm_q, wm_d, ss_q, ss_d;
  logic [2:0]        pass_q, pass_d;
  logic              err_q, err_d;
  logic [31:0]       tmo_q, tmo_d;
  cfg_t              cfg_q, cfg_d;

  logic [ProdW-1:0]  p_full, wm_full, ss_full;
  logic [EndW-1:0]   end_full;
  logic              calc_bad;

  // Layout: Q at 0, K at P, V at 2P, S at 3P, Z at 3P+SS in the result SRAM;
  // weights Wq/Wk/Wv sit back to back after the header word.
  function automatic cfg_t pass_cfg(input logic [2:0] pid, input logic [DIM_W-1:0] n,
                                    input logic [DIM_W-1:0] d, input logic [DIM_W-1:0] wc,
                                    input logic [ADDR_W-1:0] p, input logic [ADDR_W-1:0] wm,
                                    input logic [ADDR_W-1:0] ss);
    cfg_t              c;
    logic [ADDR_W-1:0] p3;
    c  = '0;
    p3 = p + (p << 1);
    case (pid)
      3'd0: begin
        c.a_base = ADDR_W'(1);
        c.b_base = ADDR_W'(1);
        c.m = n; c.k = d; c.n = wc;
      end
      3'd1: begin
        c.a_base = ADDR_W'(1);
        c.b_base = ADDR_W'(1) + wm;
        c.c_base = p;
        c.copy   = 1'b1;
        c.m = n; c.k = d; c.n = wc;
      end
      3'd2: begin
        c.a_base = ADDR_W'(1);
        c.b_base = ADDR_W'(1) + (wm << 1);
        c.c_base = p << 1;
        c.s_base = p;
        c.copy   = 1'b1;
        c.m = n; c.k = d; c.n = wc;
      end
      3'd3: begin
        c.a_sel  = 1'b1;
        c.b_sel  = 1'b1;
        c.b_tr   = 1'b1;
        c.c_base = p3;
        c.m = n; c.k = wc; c.n = n;
      end
      3'd4: begin
        c.a_sel  = 1'b1;
        c.b_sel  = 1'b1;
        c.a_base = p3;
        c.b_base = p;
        c.c_base = p3 + ss;
        c.m = n; c.k = n; c.n = wc;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Full-width products of the latched header fields and the overflow check.
  always_comb begin
    p_full   = ProdW'(n_q) * ProdW'(wc_q);
    wm_full  = ProdW'(wr_q) * ProdW'(wc_q);
    ss_full  = ProdW'(n_q) * ProdW'(n_q);
    end_full = EndW'({p_full, 2'b00}) + EndW'(ss_full);
    calc_bad = (n_q == '0) || (d_q == '0) || (wr_q == '0) || (wc_q == '0) ||
               (d_q != wr_q) || (end_full > EndLimit);
  end

  // Next-state logic for the job sequencer.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    d_d     = d_q;
    wr_d    = wr_q;
    wc_d    = wc_q;
    p_d     = p_q;
    wm_d    = wm_q;
    ss_d    = ss_q;
    pass_d  = pass_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    cfg_d   = cfg_q;
    unique case (state_q)
      StIdle: begin
        if (dut_valid) begin
          err_d   = 1'b0;
          state_d = StHdrRd;
        end
      end
      StHdrRd: state_d = StHdrLat;
      StHdrLat: begin
        n_d     = DIM_W'(tb__dut__sram_input_read_data[31:16]);
        d_d     = DIM_W'(tb__dut__sram_input_read_data[15:0]);
        wr_d    = DIM_W'(tb__dut__sram_weight_read_data[31:16]);
        wc_d    = DIM_W'(tb__dut__sram_weight_read_data[15:0]);
        state_d = StCalc;
      end
      StCalc: begin
        p_d  = ADDR_W'(p_full);
        wm_d = ADDR_W'(wm_full);
        ss_d = ADDR_W'(ss_full);
        if (calc_bad) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          pass_d  = 3'd0;
          cfg_d   = pass_cfg(3'd0, n_q, d_q, wc_q, ADDR_W'(p_full), ADDR_W'(wm_full),
                             ADDR_W'(ss_full));
          state_d = StIssue;
        end
      end
      StIssue: begin
        tmo_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        // A done in the expiry cycle wins over the timeout.
        if (eng_done) begin
          if (pass_q == 3'd4) begin
            state_d = StDone;
          end else begin
            pass_d  = pass_q + 3'd1;
            cfg_d   = pass_cfg(pass_q + 3'd1, n_q, d_q, wc_q, p_q, wm_q, ss_q);
            state_d = StIssue;
          end
        end else if ((TIMEOUT_CYC != 0) && ((tmo_q + 32'd1) == TIMEOUT_CYC)) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      n_q     <= '0;
      d_q     <= '0;
      wr_q    <= '0;
      wc_q    <= '0;
      p_q     <= '0;
      wm_q    <= '0;
      ss_q    <= '0;
      pass_q  <= '0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
      cfg_q   <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      d_q     <= d_d;
      wr_q    <= wr_d;
      wc_q    <= wc_d;
      p_q     <= p_d;
      wm_q    <= wm_d;
      ss_q    <= ss_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      cfg_q   <= cfg_d;
    end
  end

  assign dut_ready        = (state_q == StIdle);
  assign hdr_rd_active    = (state_q == StHdrRd) || (state_q == StHdrLat);
  assign hdr_read_address = '0;
  assign eng_start        = (state_q == StIssue);
  assign pass_id          = pass_q;
  assign err              = err_q;
  assign cfg_a_sel        = cfg_q.a_sel;
  assign cfg_b_sel        = cfg_q.b_sel;
  assign cfg_b_transpose  = cfg_q.b_tr;
  assign cfg_copy_scratch = cfg_q.copy;
  assign cfg_a_base       = cfg_q.a_base;
  assign cfg_b_base       = cfg_q.b_base;
  assign cfg_c_base       = cfg_q.c_base;
  assign cfg_s_base       = cfg_q.s_base;
  assign cfg_m            = cfg_q.m;
  assign cfg_k            = cfg_q.k;
  assign cfg_n            = cfg_q.n;

endmodule

// File: tb/tb_attn_pass_scheduler.sv
// Bench for attn_pass_scheduler: one instance without timeout driven by
// directed and random jobs against a pass-table model, and one instance with an
// 8-cycle timeout for the expiry boundary.
module tb_attn_pass_scheduler;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  logic          dut_valid, dut_ready, hdr_rd_active, eng_start, eng_done, err;
  logic [AW-1:0] hdr_read_address;
  logic [31:0]   in_hdr, wt_hdr;
  logic [2:0]    pass_id;
  logic          cfg_a_sel, cfg_b_sel, cfg_b_transpose, cfg_copy_scratch;
  logic [AW-1:0] cfg_a_base, cfg_b_base, cfg_c_base, cfg_s_base;
  logic [DW-1:0] cfg_m, cfg_k, cfg_n;

  logic          t_valid, t_ready, t_hdr_rd_active, t_eng_start, t_done, t_err;
  logic [AW-1:0] t_hdr_read_address;
  logic [31:0]   t_in, t_wt;
  logic [2:0]    t_pass_id;
  logic          t_a_sel, t_b_sel, t_b_tr, t_copy;
  logic [AW-1:0] t_a_base, t_b_base, t_c_base, t_s_base;
  logic [DW-1:0] t_m, t_k, t_n;

  attn_pass_scheduler #(.ADDR_W(AW), .DIM_W(DW), .TIMEOUT_CYC(0)) dut (
    .clk(clk), .reset_n(reset_n), .dut_valid(dut_valid), .dut_ready(dut_ready),
    .hdr_rd_active(hdr_rd_active), .hdr_read_address(hdr_read_address),
    .tb__dut__sram_input_read_data(in_hdr), .tb__dut__sram_weight_read_data(wt_hdr),
    .eng_start(eng_start), .eng_done(eng_done), .pass_id(pass_id),
    .cfg_a_sel(cfg_a_sel), .cfg_b_sel(cfg_b_sel), .cfg_b_transpose(cfg_b_transpose),
    .cfg_a_base(cfg_a_base), .cfg_b_base(cfg_b_base), .cfg_c_base(cfg_c_base),
    .cfg_s_base(cfg_s_base), .cfg_copy_scratch(cfg_copy_scratch),
    .cfg_m(cfg_m), .cfg_k(cfg_k), .cfg_n(cfg_n), .err(err)
  );

  attn_pass_scheduler #(.ADDR_W(AW), .DIM_W(DW), .TIMEOUT_CYC(8)) dut_t (
    .clk(clk), .reset_n(reset_n), .dut_valid(t_valid), .dut_ready(t_ready),
    .hdr_rd_active(t_hdr_rd_active), .hdr_read_address(t_hdr_read_address),
    .tb__dut__sram_input_read_data(t_in), .tb__dut__sram_weight_read_data(t_wt),
    .eng_start(t_eng_start), .eng_done(t_done), .pass_id(t_pass_id),
    .cfg_a_sel(t_a_sel), .cfg_b_sel(t_b_sel), .cfg_b_transpose(t_b_tr),
    .cfg_a_base(t_a_base), .cfg_b_base(t_b_base), .cfg_c_base(t_c_base),
    .cfg_s_base(t_s_base), .cfg_copy_scratch(t_copy),
    .cfg_m(t_m), .cfg_k(t_k), .cfg_n(t_n), .err(t_err)
  );

  int checks   = 0;
  int failures = 0;

  // Start pulses are counted on the falling edge, well away from state updates.
  int start_cnt   = 0;
  int t_start_cnt = 0;
  always @(negedge clk) if (eng_start === 1'b1) start_cnt++;
  always @(negedge clk) if (t_eng_start === 1'b1) t_start_cnt++;

  // Expected job outcome and per-pass configuration.
  bit          e_err;
  logic [3:0]  e_flags[5];  // {a_sel, b_sel, transpose, copy_scratch}
  logic [15:0] e_a[5], e_b[5], e_c[5], e_s[5], e_m[5], e_k[5], e_n[5];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pass(input int p, input logic [3:0] fl, input longint a, input longint b,
                          input longint c, input longint s, input longint m, input longint k,
                          input longint n);
    e_flags[p] = fl;
    e_a[p] = 16'(a); e_b[p] = 16'(b); e_c[p] = 16'(c); e_s[p] = 16'(s);
    e_m[p] = 16'(m); e_k[p] = 16'(k); e_n[p] = 16'(n);
  endtask

  // Memory layout from the header dimensions, in plain integer arithmetic.
  task automatic build_model(input longint n, input longint d, input longint wr,
                             input longint wc);
    longint p, wm, ss, fin;
    p   = n * wc;
    wm  = wr * wc;
    ss  = n * n;
    fin = 3 * p + ss + n * wc;
    e_err = (n == 0) || (d == 0) || (wr == 0) || (wc == 0) || (d != wr) || (fin > 65536);
    set_pass(0, 4'b0000, 1,     1,          0,          0, n, d,  wc);
    set_pass(1, 4'b0001, 1,     1 + wm,     p,          0, n, d,  wc);
    set_pass(2, 4'b0001, 1,     1 + 2 * wm, 2 * p,      p, n, d,  wc);
    set_pass(3, 4'b1110, 0,     0,          3 * p,      0, n, wc, n);
    set_pass(4, 4'b1100, 3 * p, p,          3 * p + ss, 0, n, n,  wc);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"}, dut_ready, 1);
    check_eq({tag, "_start"}, eng_start, 0);
    check_eq({tag, "_hdr_rd"}, hdr_rd_active, 0);
    check_eq({tag, "_err"}, err, 0);
    check_eq({tag, "_pass_id"}, pass_id, 0);
    check_eq({tag, "_cfg"}, {cfg_a_sel, cfg_b_sel, cfg_b_transpose, cfg_copy_scratch,
                             cfg_a_base, cfg_b_base, cfg_c_base, cfg_s_base}, 0);
    check_eq({tag, "_dims"}, {cfg_m, cfg_k, cfg_n}, 0);
  endtask

  // One job on the untimed instance. dly<0 picks a random engine latency per
  // pass; rst_pass>=0 asserts reset in that pass's WAIT and abandons the job.
  task automatic run_job(input longint n, input longint d, input longint wr, input longint wc,
                         input int dly, input bit spurious, input bit chain, input int rst_pass);
    int s0, dl;
    build_model(n, d, wr, wc);
    in_hdr    = {n[15:0], d[15:0]};
    wt_hdr    = {wr[15:0], wc[15:0]};
    dut_valid = 1'b1;
    check_eq("idle_ready", dut_ready, 1);
    step();
    dut_valid = 1'b0;
    s0 = start_cnt;
    check_eq("hdr_rd_active", hdr_rd_active, 1);
    check_eq("hdr_addr", hdr_read_address, 0);
    check_eq("busy_ready", dut_ready, 0);
    check_eq("err_cleared", err, 0);
    if (spurious) eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    check_eq("hdr_lat_active", hdr_rd_active, 1);
    step();
    check_eq("calc_no_start", eng_start, 0);
    check_eq("calc_rd_off", hdr_rd_active, 0);
    step();
    if (!e_err) begin
      for (int p = 0; p < 5; p++) begin
        check_eq($sformatf("p%0d_start", p), eng_start, 1);
        check_eq($sformatf("p%0d_id", p), pass_id, p);
        check_eq($sformatf("p%0d_flags", p),
                 {cfg_a_sel, cfg_b_sel, cfg_b_transpose, cfg_copy_scratch}, e_flags[p]);
        check_eq($sformatf("p%0d_a_base", p), cfg_a_base, e_a[p]);
        check_eq($sformatf("p%0d_b_base", p), cfg_b_base, e_b[p]);
        check_eq($sformatf("p%0d_c_base", p), cfg_c_base, e_c[p]);
        check_eq($sformatf("p%0d_s_base", p), cfg_s_base, e_s[p]);
        check_eq($sformatf("p%0d_mkn", p), {cfg_m, cfg_k, cfg_n}, {e_m[p], e_k[p], e_n[p]});
        if (spurious && p == 0) eng_done = 1'b1;
        step();
        eng_done = 1'b0;
        check_eq($sformatf("p%0d_wait_no_start", p), eng_start, 0);
        check_eq($sformatf("p%0d_wait_id", p), pass_id, p);
        if (p == rst_pass) begin
          #2 reset_n = 1'b0;
          #1 check_reset_outputs("async_rst");
          reset_n = 1'b1;
          s0 = start_cnt;
          repeat (4) step();
          check_eq("rst_no_start", start_cnt - s0, 0);
          check_eq("rst_idle_ready", dut_ready, 1);
          return;
        end
        dl = (dly < 0) ? int'($urandom_range(0, 12)) : dly;
        repeat (dl) step();
        eng_done = 1'b1;
        step();
        eng_done = 1'b0;
      end
      check_eq("done_cfg_held", {cfg_a_base, cfg_c_base}, {e_a[4], e_c[4]});
    end
    check_eq("done_err", err, e_err);
    check_eq("done_ready", dut_ready, 0);
    check_eq("done_no_start", eng_start, 0);
    check_eq("start_count", start_cnt - s0, e_err ? 0 : 5);
    if (chain) dut_valid = 1'b1;
    step();
    check_eq("back_idle_ready", dut_ready, 1);
    check_eq("idle_err_held", err, e_err);
  endtask

  initial begin
    longint rn, rd, rwr, rwc;
    int     t0;
    reset_n   = 1'b0;
    dut_valid = 1'b0;
    eng_done  = 1'b0;
    in_hdr    = '0;
    wt_hdr    = '0;
    t_valid   = 1'b0;
    t_done    = 1'b0;
    t_in      = '0;
    t_wt      = '0;
    #1 check_reset_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;
    step();

    run_job(4, 4, 4, 4, 19, 1'b0, 1'b0, -1);      // basic
    run_job(2, 3, 3, 5, 3, 1'b1, 1'b0, -1);       // non-square, spurious done
    run_job(4, 3, 4, 4, 0, 1'b0, 1'b0, -1);       // dimension mismatch
    run_job(0, 4, 4, 4, 0, 1'b0, 1'b0, -1);       // zero dimension
    run_job(3, 2, 2, 4, -1, 1'b0, 1'b1, -1);      // dut_valid held through DONE
    run_job(1, 1, 1, 1, -1, 1'b0, 1'b0, -1);
    run_job(128, 1, 1, 96, 0, 1'b0, 1'b0, -1);    // end address exactly 2^16
    run_job(128, 1, 1, 97, 0, 1'b0, 1'b0, -1);    // one column past the limit
    run_job(4, 4, 4, 4, 5, 1'b0, 1'b0, 2);        // reset in V-pass WAIT
    run_job(2, 2, 2, 2, -1, 1'b0, 1'b0, -1);      // restarts from Q

    for (int j = 0; j < 25; j++) begin
      rn  = $urandom_range(1, 8);
      rwc = $urandom_range(1, 8);
      rd  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3000) : $urandom_range(1, 8);
      rwr = rd;
      case ($urandom_range(0, 9))
        0: begin
          case ($urandom_range(0, 3))
            0: rn = 0;
            1: rd = 0;
            2: rwr = 0;
            default: rwc = 0;
          endcase
        end
        1: rwr = rd + 1;
        2: begin
          rn  = $urandom_range(100, 300);
          rwc = $urandom_range(40, 200);
        end
        default: ;
      endcase
      run_job(rn, rd, rwr, rwc, -1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
    end
    dut_valid = 1'b0;

    // Timeout: engine never answers.
    t_in    = {16'd4, 16'd4};
    t_wt    = {16'd4, 16'd4};
    t0      = t_start_cnt;
    t_valid = 1'b1;
    step();
    t_valid = 1'b0;
    repeat (3) step();
    check_eq("t_issue", t_eng_start, 1);
    step();
    for (int i = 1; i <= 8; i++) begin
      check_eq($sformatf("t_wait%0d_err", i), t_err, 0);
      check_eq($sformatf("t_wait%0d_ready", i), t_ready, 0);
      step();
    end
    check_eq("t_done_err", t_err, 1);
    check_eq("t_done_no_start", t_eng_start, 0);
    step();
    check_eq("t_idle_ready", t_ready, 1);
    check_eq("t_idle_err", t_err, 1);
    repeat (3) step();
    check_eq("t_single_start", t_start_cnt - t0, 1);

    // Done arriving in the expiry cycle counts as done.
    t_valid = 1'b1;
    step();
    t_valid = 1'b0;
    check_eq("t2_err_cleared", t_err, 0);
    repeat (3) step();
    step();
    repeat (7) step();
    t_done = 1'b1;
    step();
    t_done = 1'b0;
    check_eq("t2_expiry_done_start", t_eng_start, 1);
    check_eq("t2_expiry_done_id", t_pass_id, 1);
    check_eq("t2_expiry_done_err", t_err, 0);
    for (int p = 1; p < 5; p++) begin
      step();
      t_done = 1'b1;
      step();
      t_done = 1'b0;
    end
    check_eq("t2_final_err", t_err, 0);
    check_eq("t2_z_c_base", t_c_base, 64);
    step();
    check_eq("t2_idle_ready", t_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
